// File: rtl/display_pkg.sv
// Shared types and the 7-segment glyph table for the result display driver.
// Decimal conversion is enabled by defining BCD_DISPLAY_EN.
package display_pkg;

  localparam int N_DIGITS = 8;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADJ    = 3'd2,
    SHIFT  = 3'd3,
    COMMIT = 3'd4
  } conv_state_e;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input digit_t d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to five BCD digits,
// one add-3 cycle and one shift cycle per input bit.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  // Handshake: start is a one-cycle request sampled only while busy is low;
  // bin is captured on that edge. busy stays high for the 32 work cycles and
  // done is high during the final shift cycle, so bcd is valid from the next
  // cycle until the following start.
  logic [35:0] sh_q;
  logic [3:0]  bit_q;
  logic        adj_phase_q;

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sh_q        <= '0;
      bit_q       <= '0;
      adj_phase_q <= 1'b0;
      busy        <= 1'b0;
    end else if (start && !busy) begin
      sh_q        <= {20'b0, bin};
      bit_q       <= '0;
      adj_phase_q <= 1'b1;
      busy        <= 1'b1;
    end else if (busy) begin
      if (adj_phase_q) begin
        sh_q[35:16] <= add3(sh_q[35:16]);
        adj_phase_q <= 1'b0;
      end else begin
        sh_q        <= sh_q << 1;
        adj_phase_q <= 1'b1;
        bit_q       <= bit_q + 4'd1;
        if (bit_q == 4'd15) busy <= 1'b0;
      end
    end
  end

  assign done = busy && !adj_phase_q && (bit_q == 4'd15);
  assign bcd  = sh_q[35:16];

endmodule

// File: rtl/rpn_display_driver.sv
// Result display driver: latches each new calculator result into an 8-digit
// buffer (hex, or decimal when BCD_DISPLAY_EN is defined) and scans it out.
module rpn_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] ToDisplay,
  input  logic [3:0]  Flags,
  output logic [6:0]  Segments,
  output logic [7:0]  Anodes,
  output logic [3:0]  FlagLeds,
  output logic        Busy,
  output conv_state_e dbg_state
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]          in_q;
  logic [15:0]          last_src;
  conv_state_e          state_q, state_d;
  digit_t               digit_q [N_DIGITS];
  logic [N_DIGITS-1:0]  blank_q;
  digit_t               commit_dig [N_DIGITS];
  logic [N_DIGITS-1:0]  commit_blank;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           idx_q;

`ifdef BCD_DISPLAY_EN
  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [19:0] conv_bcd;
  logic        seen_nz;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .resetN (resetN),
    .start  (conv_start),
    .bin    (last_src),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      in_q     <= '0;
      last_src <= '0;
      state_q  <= IDLE;
      FlagLeds <= '0;
    end else begin
      in_q     <= ToDisplay;
      FlagLeds <= Flags;
      state_q  <= state_d;
      // last_src freezes the value being converted; later input changes wait for IDLE.
      if (state_q == IDLE && in_q != last_src) last_src <= in_q;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef BCD_DISPLAY_EN
    conv_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_q != last_src) begin
`ifdef BCD_DISPLAY_EN
          state_d = LOAD;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef BCD_DISPLAY_EN
      LOAD: begin
        conv_start = 1'b1;
        state_d    = ADJ;
      end
      ADJ:   state_d = SHIFT;
      SHIFT: state_d = (conv_done || !conv_busy) ? COMMIT : ADJ;
`endif
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_DIGITS; k++) commit_dig[k] = '0;
    commit_blank = '1;
`ifdef BCD_DISPLAY_EN
    seen_nz = 1'b0;
    for (int k = 0; k < 5; k++) commit_dig[k] = conv_bcd[4*k +: 4];
    // Blank leading zeros from the top digit down; digit 0 always shows.
    for (int k = 4; k >= 1; k--) begin
      seen_nz         = seen_nz || (conv_bcd[4*k +: 4] != 4'd0);
      commit_blank[k] = !seen_nz;
    end
    commit_blank[0] = 1'b0;
`else
    for (int k = 0; k < 4; k++) commit_dig[k] = last_src[4*k +: 4];
    commit_blank = 8'hF0;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < N_DIGITS; k++) digit_q[k] <= '0;
      blank_q <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    end else if (state_q == COMMIT) begin
      for (int k = 0; k < N_DIGITS; k++) digit_q[k] <= commit_dig[k];
      blank_q <= commit_blank;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      Anodes   <= 8'hFF;
      Segments <= 7'h7F;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A blank slot drives no anode at all, so at most one anode is ever low.
      Anodes   <= blank_q[idx_q] ? 8'hFF : ~(8'b1 << idx_q);
      Segments <= blank_q[idx_q] ? 7'h7F : seg7(digit_q[idx_q]);
    end
  end

  assign Busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_display_driver.sv
// Bench for rpn_display_driver with REFRESH_DIV=4; follows BCD_DISPLAY_EN for decimal mode.
module tb_rpn_display_driver;
  import display_pkg::*;

`ifdef BCD_DISPLAY_EN
  localparam int CONV_W = 34;
`else
  localparam int CONV_W = 1;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic [15:0] ToDisplay;
  logic [3:0]  Flags;
  logic [6:0]  Segments;
  logic [7:0]  Anodes;
  logic [3:0]  FlagLeds;
  logic        Busy;
  conv_state_e dbg_state;

  rpn_display_driver #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .ToDisplay (ToDisplay),
    .Flags     (Flags),
    .Segments  (Segments),
    .Anodes    (Anodes),
    .FlagLeds  (FlagLeds),
    .Busy      (Busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          total = 0;
  int          bad = 0;
  int          busy_run = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  logic [3:0]  flags_prev = 4'h0;
  logic [15:0] cur_val = 16'h0;
  int          exp_dig [8];
  bit          exp_lit [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, then drive fresh random flags.
  task automatic tick();
    @(negedge clk);
    chk("flag_leds", FlagLeds, resetN ? flags_prev : 4'h0);
    chk("anode_onehot", ($countones(~Anodes) <= 1), 1);
    if (!resetN) busy_run = 0;
    else if (Busy) busy_run++;
    else if (busy_run != 0) begin
      obs_q.push_back(busy_run);
      busy_run = 0;
    end
    flags_prev = 4'($urandom_range(0, 15));
    Flags = flags_prev;
  endtask

  task automatic check_busy(input string tag);
    while (exp_q.size() != 0) begin
      if (obs_q.size() == 0) begin
        chk({tag, "_busy_missing"}, 0, exp_q.pop_front());
      end else begin
        chk({tag, "_busy_width"}, obs_q.pop_front(), exp_q.pop_front());
      end
    end
    chk({tag, "_busy_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic set_expect(input int v);
    int p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
`ifdef BCD_DISPLAY_EN
      exp_dig[k] = (v / p) % 10;
      exp_lit[k] = (k < 5) && ((k == 0) || (v >= p));
      if (k < 7) p = p * 10;
`else
      exp_dig[k] = (v >> (4 * k)) & 15;
      exp_lit[k] = (k < 4);
`endif
    end
  endtask

  task automatic reset_expect();
    for (int k = 0; k < 8; k++) begin
      exp_dig[k] = 0;
      exp_lit[k] = (k == 0);
    end
  endtask

  task automatic check_frame(input string tag);
    bit seen [8];
    for (int k = 0; k < 8; k++) seen[k] = 1'b0;
    repeat (40) begin
      tick();
      if (Anodes == 8'hFF) begin
        chk({tag, "_blank_seg"}, Segments, 7'h7F);
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (!Anodes[k]) begin
            seen[k] = 1'b1;
            chk({tag, "_seg"}, Segments, seg_tab[exp_dig[k]]);
          end
        end
      end
    end
    for (int k = 0; k < 8; k++) chk({tag, "_lit"}, seen[k], exp_lit[k]);
  endtask

  task automatic show(input logic [15:0] v, input string tag);
    if (v != cur_val) exp_q.push_back(CONV_W);
    ToDisplay = v;
    cur_val = v;
    set_expect(int'(v));
    repeat (CONV_W + 8) tick();
    check_busy(tag);
    check_frame(tag);
  endtask

  initial begin
    resetN = 1'b0;
    ToDisplay = 16'h0;
    Flags = 4'h0;
    repeat (3) tick();
    chk("rst_segments", Segments, 7'h7F);
    chk("rst_anodes", Anodes, 8'hFF);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_state", dbg_state, IDLE);

    resetN = 1'b1;
    tick();
    chk("rel_anodes", Anodes, 8'hFE);
    chk("rel_segments", Segments, 7'b1000000);
    reset_expect();
    check_frame("reset");

    show(16'hBEEF, "beef");
    show(16'd65535, "max");
    show(16'd0, "zero");
    show(16'd10000, "ten_k");
    show(16'd1, "one");

    // A change mid-conversion finishes the old value, then converts the new one.
    ToDisplay = 16'd1234;
    cur_val = 16'd1234;
    exp_q.push_back(CONV_W);
    repeat (10) tick();
    ToDisplay = 16'd9;
    cur_val = 16'd9;
    exp_q.push_back(CONV_W);
    repeat (2 * CONV_W + 12) tick();
    check_busy("change");
    set_expect(9);
    check_frame("change");

    // Reset in the middle of converting 4321.
    ToDisplay = 16'd4321;
    cur_val = 16'd4321;
`ifndef BCD_DISPLAY_EN
    exp_q.push_back(CONV_W);
`endif
    repeat (10) tick();
    resetN = 1'b0;
    #1;
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_anodes", Anodes, 8'hFF);
    chk("midrst_segments", Segments, 7'h7F);
    chk("midrst_state", dbg_state, IDLE);
    repeat (3) tick();
    resetN = 1'b1;
    exp_q.push_back(CONV_W);
    tick();
    chk("midrst_rel_anodes", Anodes, 8'hFE);
    chk("midrst_rel_segments", Segments, 7'b1000000);
    repeat (CONV_W + 8) tick();
    check_busy("midrst");
    set_expect(4321);
    check_frame("midrst");

    Flags = 4'b1010;
    flags_prev = 4'b1010;
    tick();

    for (int i = 0; i < 6; i++) begin
      show(16'($urandom_range(0, 65535)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
